// File: rtl/int_collect_pkg.sv
// Shared types and sizing for the interrupt collector and its event counters.
package int_collect_pkg;

  localparam int unsigned CH_NUM_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned SEL_W      = 5;
  localparam int unsigned HOLD_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/int_event_cnt.sv
// Saturating per-channel event counter, cleared by a read; a same-cycle
// increment survives the clear so no event is lost.
module int_event_cnt
  import int_collect_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (rd_clr) begin
      r_cnt <= CNT_W'(inc);
    end else if (inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/int_collect.sv
// Interrupt collector: sticky status, masked level irq with ms hold-off.
// Per-channel event counters exist only when INT_COLLECT_CNT_EN is defined.
module int_collect
  import int_collect_pkg::*;
#(
  parameter int          U_DLY  = 1,
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] into,
  input  logic              ms_pulse,
  input  logic [CH_NUM-1:0] int_mask,
  input  logic [HOLD_W-1:0] holdoff_ms,
  input  logic              clr_req,
  input  logic [CH_NUM-1:0] clr_mask,
  output logic              clr_ack,
  output logic [CH_NUM-1:0] int_status,
  output logic              irq,
  input  logic              cnt_rd,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              cnt_vld
);

  if (CH_NUM < 1 || CH_NUM > 32) begin : g_bad_ch
    $error("int_collect: CH_NUM must be 1..32");
  end
  if (U_DLY < 0) begin : g_bad_dly
    $error("int_collect: U_DLY must be non-negative");
  end

  logic [CH_NUM-1:0] r_status;
  logic              r_clr_ack;
  logic              w_pending;
  logic [CH_NUM-1:0] w_clr_bits;
  state_e            r_state;
  logic              r_irq;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]  r_cnt_data;
  logic              r_cnt_vld;
  logic [CNT_W-1:0]  w_rd_val;

  // Set has priority over clear, so an event coinciding with its clear is kept.
  assign w_clr_bits = clr_req ? clr_mask : '0;
  assign w_pending  = |(r_status & ~int_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status  <= '0;
      r_clr_ack <= 1'b0;
    end else begin
      r_status  <= (r_status & ~w_clr_bits) | into;
      r_clr_ack <= clr_req;
    end
  end

  // irq is asserted exactly while in ACTIVE; HOLD enforces the quiet period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_irq      <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_state <= ACTIVE;
            r_irq   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!w_pending) begin
            r_state    <= HOLD;
            r_irq      <= 1'b0;
            r_hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (r_hold_cnt >= holdoff_ms) begin
            r_state <= IDLE;
          end else if (ms_pulse) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

`ifdef INT_COLLECT_CNT_EN
  logic [CNT_W-1:0] w_cnt [CH_NUM];

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_cnt
    int_event_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (into[gi]),
      .rd_clr(cnt_rd && (cnt_sel == SEL_W'(gi))),
      .cnt   (w_cnt[gi])
    );
  end

  // Out-of-range selects match no channel and read back 0.
  always_comb begin
    w_rd_val = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (cnt_sel == SEL_W'(i)) w_rd_val = w_cnt[i];
    end
  end
`else
  logic w_unused_sel;
  assign w_unused_sel = ^cnt_sel;
  assign w_rd_val     = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_vld  <= 1'b0;
      r_cnt_data <= '0;
    end else begin
      r_cnt_vld <= cnt_rd;
      if (cnt_rd) r_cnt_data <= w_rd_val;
    end
  end

  assign clr_ack    = r_clr_ack;
  assign int_status = r_status;
  assign irq        = r_irq;
  assign cnt_data   = r_cnt_data;
  assign cnt_vld    = r_cnt_vld;

endmodule

// File: tb/tb_int_collect.sv
// Randomised scoreboard bench for int_collect against a behavioural model.
module tb_int_collect;

  localparam int CH   = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] into;
  logic          ms_pulse;
  logic [CH-1:0] int_mask;
  logic [7:0]    holdoff_ms;
  logic          clr_req;
  logic [CH-1:0] clr_mask;
  logic          clr_ack;
  logic [CH-1:0] int_status;
  logic          irq;
  logic          cnt_rd;
  logic [4:0]    cnt_sel;
  logic [CW-1:0] cnt_data;
  logic          cnt_vld;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_q[$];

  logic [CH-1:0] m_status;
  int            m_cnt[CH];
  bit            m_irq, m_hold, m_ack;
  int            m_ticks;

  int_collect #(
    .U_DLY (1),
    .CH_NUM(CH),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .into      (into),
    .ms_pulse  (ms_pulse),
    .int_mask  (int_mask),
    .holdoff_ms(holdoff_ms),
    .clr_req   (clr_req),
    .clr_mask  (clr_mask),
    .clr_ack   (clr_ack),
    .int_status(int_status),
    .irq       (irq),
    .cnt_rd    (cnt_rd),
    .cnt_sel   (cnt_sel),
    .cnt_data  (cnt_data),
    .cnt_vld   (cnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance for one clock edge using the inputs currently applied.
  task automatic step();
    bit pend;
    int sel, rd_val;
    if (!rst_n) begin
      m_status = '0;
      m_irq    = 1'b0;
      m_hold   = 1'b0;
      m_ticks  = 0;
      m_ack    = 1'b0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else begin
      pend = |(m_status & ~int_mask);
      if (m_irq) begin
        if (!pend) begin
          m_irq = 1'b0; m_hold = 1'b1; m_ticks = 0;
        end
      end else if (m_hold) begin
        if (m_ticks >= int'(holdoff_ms)) m_hold = 1'b0;
        else if (ms_pulse) m_ticks++;
      end else if (pend) begin
        m_irq = 1'b1;
      end
      sel = int'(cnt_sel);
      if (cnt_rd) begin
`ifdef INT_COLLECT_CNT_EN
        rd_val = (sel < CH) ? m_cnt[sel] : 0;
`else
        rd_val = 0;
`endif
        exp_q.push_back(CW'(rd_val));
      end
      for (int i = 0; i < CH; i++) begin
        if (cnt_rd && sel == i) m_cnt[i] = into[i] ? 1 : 0;
        else if (into[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      end
      m_status = (m_status & ~(clr_req ? clr_mask : '0)) | into;
      m_ack    = clr_req;
    end
    @(posedge clk);
    #1;
    chk("status", 32'(int_status), 32'(m_status));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("clr_ack", 32'(clr_ack), 32'(m_ack));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Read-data monitor: every cnt_vld must match the oldest outstanding read.
  always @(negedge clk) begin
    if (cnt_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cnt_vld_unexpected actual=1 required=0 at %0t", $time);
      end else begin
        chk("cnt_data", 32'(cnt_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int exp_c;
    rst_n = 1'b0; into = '0; ms_pulse = 1'b0; int_mask = '0; holdoff_ms = '0;
    clr_req = 1'b0; clr_mask = '0; cnt_rd = 1'b0; cnt_sel = '0;
    steps(3);
    chk("rst_cnt_vld", 32'(cnt_vld), 32'd0);
    chk("rst_cnt_data", 32'(cnt_data), 32'd0);
    rst_n = 1'b1;
    steps(5);

    // Basic event
    into = 8'h08; step(); into = '0;
    chk("t1_status", 32'(int_status), 32'h08);
    step();
    chk("t1_irq", 32'(irq), 32'd1);

    // Clear followed by hold-off of 2 ms
    holdoff_ms = 8'd2; clr_req = 1'b1; clr_mask = 8'h08; step();
    chk("t2_ack", 32'(clr_ack), 32'd1);
    clr_req = 1'b0; into = 8'h08; step(); into = '0;
    chk("t2_drop", 32'(irq), 32'd0);
    steps(3);
    ms_pulse = 1'b1; step(); ms_pulse = 1'b0; steps(2);
    ms_pulse = 1'b1; step(); ms_pulse = 1'b0;
    chk("t2_hold", 32'(irq), 32'd0);
    steps(2);
    chk("t2_reassert", 32'(irq), 32'd1);

    // Set/clear collision
    into = 8'h20; clr_req = 1'b1; clr_mask = 8'h20; step();
    into = '0; clr_req = 1'b0;
    chk("t3_bit5", 32'(int_status[5]), 32'd1);
    step();
    chk("t3_irq", 32'(irq), 32'd1);

    // Masking
    holdoff_ms = 8'd0; clr_req = 1'b1; clr_mask = 8'hFF; step();
    clr_req = 1'b0; steps(3);
    int_mask = 8'hFF; into = 8'h01; step(); into = '0; steps(2);
    chk("t4_masked_irq", 32'(irq), 32'd0);
    chk("t4_status0", 32'(int_status[0]), 32'd1);
    int_mask = 8'hFE; steps(2);
    chk("t4_unmask", 32'(irq), 32'd1);

    // Counter read colliding with an increment
    for (int p = 0; p < 3; p++) begin
      into = 8'h04; step(); into = '0; step();
    end
    into = 8'h04; cnt_rd = 1'b1; cnt_sel = 5'd2; step();
    into = '0; cnt_rd = 1'b0;
`ifdef INT_COLLECT_CNT_EN
    exp_c = 3;
`else
    exp_c = 0;
`endif
    chk("t5_read1", 32'(cnt_data), 32'(exp_c));
    cnt_rd = 1'b1; step(); cnt_rd = 1'b0;
    chk("t5_read2", 32'(cnt_data), 32'(exp_c == 3 ? 1 : 0));

    // Saturation, out-of-range read, reset during HOLD
    into = 8'h02; steps(20); into = '0;
    cnt_rd = 1'b1; cnt_sel = 5'd1; step();
    chk("t6_sat", 32'(cnt_data), 32'(exp_c == 3 ? MAXC : 0));
    cnt_sel = 5'd20; step(); cnt_rd = 1'b0;
    chk("t6_oob", 32'(cnt_data), 32'd0);
    int_mask = '0; holdoff_ms = 8'd5; step();
    clr_req = 1'b1; clr_mask = 8'hFF; step(); clr_req = 1'b0; step();
    chk("t6_in_hold", 32'(irq), 32'd0);
    rst_n = 1'b0; cnt_rd = 1'b1; cnt_sel = 5'd1; step();
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_status", 32'(int_status), 32'd0);
    chk("t6_rst_vld", 32'(cnt_vld), 32'd0);
    cnt_rd = 1'b0; step(); rst_n = 1'b1;

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      into       = CH'($urandom & $urandom & $urandom);
      ms_pulse   = ($urandom_range(0, 7) == 0);
      clr_req    = ($urandom_range(0, 5) == 0);
      clr_mask   = CH'($urandom);
      cnt_rd     = ($urandom_range(0, 4) == 0);
      cnt_sel    = 5'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) int_mask = CH'($urandom & $urandom);
      if ($urandom_range(0, 29) == 0) holdoff_ms = 8'($urandom_range(0, 3));
      step();
    end

    rst_n = 1'b1; into = '0; clr_req = 1'b0; cnt_rd = 1'b0; ms_pulse = 1'b0;
    step();
    @(negedge clk);
    #1;
    chk("reads_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
